// File: rtl/pipe_defs_pkg.sv
// pipe_defs_pkg: constants and types shared by the ID/EX stage.
//   DW, RW        : default datapath and register-index widths
//   ALU_*         : ALU class codes driven on aluCode
//   FN_*          : function codes driven on operation
//   ctrl_t        : the four pipeline control bits that travel with an instruction
//   CTRL_BUBBLE   : control value carried by a bubble (nothing written, no memory access)
package pipe_defs_pkg;

  localparam int DW = 32;
  localparam int RW = 5;

  localparam logic [2:0] ALU_ARITH = 3'b000;
  localparam logic [2:0] ALU_EQ    = 3'b001;
  localparam logic [2:0] ALU_LT    = 3'b010;
  localparam logic [2:0] ALU_GT    = 3'b011;
  localparam logic [2:0] ALU_CLZO  = 3'b100;
  localparam logic [2:0] ALU_ADDI  = 3'b101;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  typedef struct packed {
    logic regWrite;
    logic memRead;
    logic memWrite;
    logic memToReg;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: operand forwarding mux for one ALU source.
// Ports:
//   srcIdx         latched source register index
//   srcValue       latched register-file value
//   exmem*         EX/MEM producer (write enable, destination, result)
//   memwb*         MEM/WB producer (write enable, destination, data)
//   fwdValue       value the ALU should see for this source
// The younger EX/MEM producer takes priority over MEM/WB; register 0 is never forwarded.
module fwd_unit #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] srcIdx,
  input  logic [DW-1:0] srcValue,
  input  logic          exmemRegWrite,
  input  logic [RW-1:0] exmemRd,
  input  logic [DW-1:0] exmemResult,
  input  logic          memwbRegWrite,
  input  logic [RW-1:0] memwbRd,
  input  logic [DW-1:0] memwbData,
  output logic [DW-1:0] fwdValue
);

  logic srcNonZero;
  assign srcNonZero = (srcIdx != '0);

  always_comb begin
    fwdValue = srcValue;
    if (srcNonZero && memwbRegWrite && (memwbRd == srcIdx)) fwdValue = memwbData;
    if (srcNonZero && exmemRegWrite && (exmemRd == srcIdx)) fwdValue = exmemResult;
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register and ALU operand front end.
// Latches decoded operands/control, presents forwarded operands to the ALU,
// and raises stall_out for hazards that forwarding cannot cover.
// Ports:
//   clk, reset                synchronous active-high reset
//   id_*                      decoded instruction from the decode stage
//   flush                     squash the instruction entering EX
//   ex_hold                   downstream busy; freeze the EX slot
//   exmem_*, memwb_*          downstream producers for forwarding / hazard checks
//   stall_out                 freeze PC and IF/ID this cycle
//   ex_*                      EX slot contents and ALU inputs
// Build option: FWD_EN
//   defined   : operands forwarded from EX/MEM and MEM/WB; only load-use stalls
//   undefined : no forwarding; stall on any RAW against EX, EX/MEM or MEM/WB
module id_ex_stage #(
  parameter int DW = pipe_defs_pkg::DW,
  parameter int RW = pipe_defs_pkg::RW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [5:0]    id_operation,
  input  logic [2:0]    id_alu_code,
  input  logic          id_alu_src,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          flush,
  input  logic          ex_hold,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_data,
  output logic          stall_out,
  output logic          ex_valid,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_store_data,
  output logic [5:0]    ex_operation,
  output logic [2:0]    ex_alu_code,
  output logic [RW-1:0] ex_rd,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg
);

  import pipe_defs_pkg::*;

  logic          validQ;
  logic [DW-1:0] rsDataQ, rtDataQ, immQ;
  logic [RW-1:0] rsQ, rtQ, rdQ;
  logic [5:0]    operationQ;
  logic [2:0]    aluCodeQ;
  logic          aluSrcQ;
  ctrl_t         ctrlQ;

  logic          rsUsed, rtUsed, hazard;
  logic [DW-1:0] rsFwd, rtFwd;

  // True when a write to rd (non-zero) feeds a source the decode slot actually reads.
  function automatic logic dependsOn(input logic we, input logic [RW-1:0] rd,
                                     input logic useRs, input logic [RW-1:0] rs,
                                     input logic useRt, input logic [RW-1:0] rt);
    return we && (rd != '0) && ((useRs && (rd == rs)) || (useRt && (rd == rt)));
  endfunction

  // An immediate-form op reads rt only when it is the store data.
  assign rsUsed = id_valid && (id_rs != '0);
  assign rtUsed = id_valid && (id_rt != '0) && (!id_alu_src || id_mem_write);

`ifdef FWD_EN
  assign hazard = dependsOn(validQ && ctrlQ.memRead, rdQ, rsUsed, id_rs, rtUsed, id_rt);

  fwd_unit #(.DW(DW), .RW(RW)) uFwdRs (
    .srcIdx(rsQ), .srcValue(rsDataQ),
    .exmemRegWrite(exmem_reg_write), .exmemRd(exmem_rd), .exmemResult(exmem_result),
    .memwbRegWrite(memwb_reg_write), .memwbRd(memwb_rd), .memwbData(memwb_data),
    .fwdValue(rsFwd)
  );

  fwd_unit #(.DW(DW), .RW(RW)) uFwdRt (
    .srcIdx(rtQ), .srcValue(rtDataQ),
    .exmemRegWrite(exmem_reg_write), .exmemRd(exmem_rd), .exmemResult(exmem_result),
    .memwbRegWrite(memwb_reg_write), .memwbRd(memwb_rd), .memwbData(memwb_data),
    .fwdValue(rtFwd)
  );
`else
  // Without bypass paths every in-flight writer is a hazard until it retires.
  assign hazard = dependsOn(validQ && ctrlQ.regWrite, rdQ, rsUsed, id_rs, rtUsed, id_rt)
               || dependsOn(exmem_reg_write, exmem_rd, rsUsed, id_rs, rtUsed, id_rt)
               || dependsOn(memwb_reg_write, memwb_rd, rsUsed, id_rs, rtUsed, id_rt);

  assign rsFwd = rsDataQ;
  assign rtFwd = rtDataQ;

  // Producer values and latched indices have no consumer in this build.
  logic unusedData;
  assign unusedData = ^{exmem_result, memwb_data, rsQ, rtQ};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      validQ     <= 1'b0;
      rsDataQ    <= '0;
      rtDataQ    <= '0;
      immQ       <= '0;
      rsQ        <= '0;
      rtQ        <= '0;
      rdQ        <= '0;
      operationQ <= '0;
      aluCodeQ   <= '0;
      aluSrcQ    <= 1'b0;
      ctrlQ      <= CTRL_BUBBLE;
    end else if (!ex_hold) begin
      if (flush || hazard) begin
        // Bubble: data fields are parked at zero so the ALU sees quiet inputs.
        validQ     <= 1'b0;
        rsDataQ    <= '0;
        rtDataQ    <= '0;
        immQ       <= '0;
        rsQ        <= '0;
        rtQ        <= '0;
        rdQ        <= '0;
        operationQ <= '0;
        aluCodeQ   <= '0;
        aluSrcQ    <= 1'b0;
        ctrlQ      <= CTRL_BUBBLE;
      end else begin
        validQ     <= id_valid;
        rsDataQ    <= id_rs_data;
        rtDataQ    <= id_rt_data;
        immQ       <= id_imm;
        rsQ        <= id_rs;
        rtQ        <= id_rt;
        rdQ        <= id_rd;
        operationQ <= id_operation;
        aluCodeQ   <= id_alu_code;
        aluSrcQ    <= id_alu_src;
        ctrlQ      <= '{regWrite: id_reg_write, memRead: id_mem_read,
                        memWrite: id_mem_write, memToReg: id_mem_to_reg};
      end
    end
  end

  assign stall_out     = hazard || ex_hold;
  assign ex_valid      = validQ;
  assign ex_a          = rsFwd;
  assign ex_store_data = rtFwd;
  assign ex_b          = aluSrcQ ? immQ : rtFwd;
  assign ex_operation  = operationQ;
  assign ex_alu_code   = aluCodeQ;
  assign ex_rd         = rdQ;
  assign ex_reg_write  = ctrlQ.regWrite && validQ;
  assign ex_mem_read   = ctrlQ.memRead  && validQ;
  assign ex_mem_write  = ctrlQ.memWrite && validQ;
  assign ex_mem_to_reg = ctrlQ.memToReg && validQ;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import pipe_defs_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_operation;
  logic [2:0]  id_alu_code;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        flush, ex_hold;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;
  logic        stall_out, ex_valid;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [5:0]  ex_operation;
  logic [2:0]  ex_alu_code;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  int passCount = 0;
  int checkCount = 0;

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_operation(id_operation), .id_alu_code(id_alu_code), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg),
    .flush(flush), .ex_hold(ex_hold),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .stall_out(stall_out), .ex_valid(ex_valid),
    .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
    .ex_operation(ex_operation), .ex_alu_code(ex_alu_code), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setInstr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rsD,
                          input logic [31:0] rtD, input logic [31:0] imm,
                          input logic [5:0] op, input logic [2:0] ac, input logic src,
                          input logic rw, input logic mr, input logic mw, input logic m2r);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsD; id_rt_data = rtD; id_imm = imm;
    id_operation = op; id_alu_code = ac; id_alu_src = src;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
  endtask

  task automatic idleProducers();
    exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_rd = '0; memwb_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; ex_hold = 1'b0;
    idleProducers();
    setInstr(1, 5'd1, 5'd2, 5'd3, 32'h10, 32'h20, 32'h30, FN_ADD, ALU_ARITH, 0, 1, 0, 0, 0);
    tick(); tick();
    checkCount++; if (ex_valid !== 1'b0) $display("FAIL rst_valid got %0d want 0", ex_valid); else passCount++;
    checkCount++; if (ex_reg_write !== 1'b0) $display("FAIL rst_regwrite got %0d want 0", ex_reg_write); else passCount++;
    checkCount++; if (ex_a !== 32'h0) $display("FAIL rst_a got %h want 0", ex_a); else passCount++;
    checkCount++; if (stall_out !== 1'b0) $display("FAIL rst_stall got %0d want 0", stall_out); else passCount++;
    reset = 1'b0;
    #1;
    checkCount++; if (ex_valid !== 1'b0) $display("FAIL rst_release_valid got %0d want 0", ex_valid); else passCount++;
    tick();
    checkCount++; if (ex_valid !== 1'b1) $display("FAIL first_load_valid got %0d want 1", ex_valid); else passCount++;
    checkCount++; if (ex_a !== 32'h10) $display("FAIL first_load_a got %h want 10", ex_a); else passCount++;
    checkCount++; if (ex_rd !== 5'd3) $display("FAIL first_load_rd got %0d want 3", ex_rd); else passCount++;
  endtask

  task automatic test_operands();
    setInstr(1, 5'd4, 5'd6, 5'd7, 32'h100, 32'h200, 32'h300, FN_SUB, ALU_ARITH, 0, 1, 0, 0, 0);
    tick();
    checkCount++; if (ex_a !== 32'h100) $display("FAIL op_a got %h want 100", ex_a); else passCount++;
    checkCount++; if (ex_b !== 32'h200) $display("FAIL op_b_reg got %h want 200", ex_b); else passCount++;
    checkCount++; if (ex_operation !== FN_SUB) $display("FAIL op_fn got %h want %h", ex_operation, FN_SUB); else passCount++;
    checkCount++; if (ex_rd !== 5'd7) $display("FAIL op_rd got %0d want 7", ex_rd); else passCount++;
    checkCount++; if (ex_reg_write !== 1'b1) $display("FAIL op_regwrite got %0d want 1", ex_reg_write); else passCount++;
    setInstr(1, 5'd9, 5'd10, 5'd11, 32'h111, 32'h222, 32'h333, FN_OR, ALU_ADDI, 1, 0, 0, 1, 0);
    tick();
    checkCount++; if (ex_b !== 32'h333) $display("FAIL op_b_imm got %h want 333", ex_b); else passCount++;
    checkCount++; if (ex_store_data !== 32'h222) $display("FAIL op_store got %h want 222", ex_store_data); else passCount++;
    checkCount++; if (ex_alu_code !== ALU_ADDI) $display("FAIL op_alucode got %0d want 5", ex_alu_code); else passCount++;
    checkCount++; if (ex_mem_write !== 1'b1) $display("FAIL op_memwrite got %0d want 1", ex_mem_write); else passCount++;
    checkCount++; if (ex_reg_write !== 1'b0) $display("FAIL op_regwrite0 got %0d want 0", ex_reg_write); else passCount++;
  endtask

  task automatic test_forward();
    setInstr(1, 5'd5, 5'd6, 5'd12, 32'hAA, 32'hBB, 32'h0, FN_ADD, ALU_ARITH, 0, 1, 0, 0, 0);
    tick();
    setInstr(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 6'd0, 3'd0, 0, 0, 0, 0, 0);
    exmem_reg_write = 1; exmem_rd = 5'd5; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 5'd5; memwb_data = 32'h22;
    #1;
`ifdef FWD_EN
    checkCount++; if (ex_a !== 32'h11) $display("FAIL fwd_exmem got %h want 11", ex_a); else passCount++;
    exmem_reg_write = 0;
    #1;
    checkCount++; if (ex_a !== 32'h22) $display("FAIL fwd_memwb got %h want 22", ex_a); else passCount++;
    memwb_reg_write = 0;
    exmem_reg_write = 1; exmem_rd = 5'd6; exmem_result = 32'h33;
    #1;
    checkCount++; if (ex_a !== 32'hAA) $display("FAIL fwd_none_a got %h want aa", ex_a); else passCount++;
    checkCount++; if (ex_b !== 32'h33) $display("FAIL fwd_rt_b got %h want 33", ex_b); else passCount++;
    checkCount++; if (ex_store_data !== 32'h33) $display("FAIL fwd_rt_store got %h want 33", ex_store_data); else passCount++;
`else
    checkCount++; if (ex_a !== 32'hAA) $display("FAIL nofwd_a got %h want aa", ex_a); else passCount++;
    checkCount++; if (ex_b !== 32'hBB) $display("FAIL nofwd_b got %h want bb", ex_b); else passCount++;
    checkCount++; if (stall_out !== 1'b0) $display("FAIL nofwd_idle_stall got %0d want 0", stall_out); else passCount++;
`endif
    idleProducers();
    setInstr(1, 5'd0, 5'd0, 5'd13, 32'h0, 32'h0, 32'h0, FN_ADD, ALU_ARITH, 0, 1, 0, 0, 0);
    tick();
    exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'hFFFF_FFFF;
    memwb_reg_write = 1; memwb_rd = 5'd0; memwb_data = 32'hFFFF_FFFF;
    #1;
    checkCount++; if (ex_a !== 32'h0) $display("FAIL r0_a got %h want 0", ex_a); else passCount++;
    checkCount++; if (ex_store_data !== 32'h0) $display("FAIL r0_store got %h want 0", ex_store_data); else passCount++;
    checkCount++; if (stall_out !== 1'b0) $display("FAIL r0_stall got %0d want 0", stall_out); else passCount++;
    idleProducers();
  endtask

  task automatic test_load_use();
    setInstr(1, 5'd1, 5'd0, 5'd8, 32'h40, 32'h0, 32'h4, FN_ADD, ALU_ADDI, 1, 1, 1, 0, 1);
    tick();
    checkCount++; if (ex_mem_read !== 1'b1) $display("FAIL lu_memread got %0d want 1", ex_mem_read); else passCount++;
    checkCount++; if (ex_mem_to_reg !== 1'b1) $display("FAIL lu_mem2reg got %0d want 1", ex_mem_to_reg); else passCount++;
    setInstr(1, 5'd2, 5'd8, 5'd9, 32'h50, 32'h60, 32'h0, FN_ADD, ALU_ARITH, 0, 1, 0, 0, 0);
    #1;
    checkCount++; if (stall_out !== 1'b1) $display("FAIL lu_stall got %0d want 1", stall_out); else passCount++;
    tick();
    checkCount++; if (ex_valid !== 1'b0) $display("FAIL lu_bubble_valid got %0d want 0", ex_valid); else passCount++;
    checkCount++; if (ex_mem_read !== 1'b0) $display("FAIL lu_bubble_memread got %0d want 0", ex_mem_read); else passCount++;
    checkCount++; if (ex_a !== 32'h0) $display("FAIL lu_bubble_a got %h want 0", ex_a); else passCount++;
    checkCount++; if (stall_out !== 1'b0) $display("FAIL lu_stall_drop got %0d want 0", stall_out); else passCount++;
    tick();
    checkCount++; if (ex_valid !== 1'b1) $display("FAIL lu_add_valid got %0d want 1", ex_valid); else passCount++;
    checkCount++; if (ex_rd !== 5'd9) $display("FAIL lu_add_rd got %0d want 9", ex_rd); else passCount++;
    checkCount++; if (ex_b !== 32'h60) $display("FAIL lu_add_b got %h want 60", ex_b); else passCount++;
    setInstr(1, 5'd1, 5'd0, 5'd8, 32'h40, 32'h0, 32'h4, FN_ADD, ALU_ADDI, 1, 1, 1, 0, 1);
    tick();
    setInstr(1, 5'd2, 5'd8, 5'd10, 32'h50, 32'h60, 32'h7, FN_ADD, ALU_ADDI, 1, 1, 0, 0, 0);
    #1;
    checkCount++; if (stall_out !== 1'b0) $display("FAIL addi_stall got %0d want 0", stall_out); else passCount++;
    tick();
    checkCount++; if (ex_rd !== 5'd10) $display("FAIL addi_rd got %0d want 10", ex_rd); else passCount++;
    checkCount++; if (ex_b !== 32'h7) $display("FAIL addi_b got %h want 7", ex_b); else passCount++;
  endtask

  task automatic test_flush_hold();
    setInstr(1, 5'd3, 5'd4, 5'd14, 32'h70, 32'h71, 32'h0, FN_AND, ALU_ARITH, 0, 1, 0, 0, 0);
    flush = 1'b1;
    tick();
    checkCount++; if (ex_valid !== 1'b0) $display("FAIL flush_valid got %0d want 0", ex_valid); else passCount++;
    checkCount++; if (ex_reg_write !== 1'b0) $display("FAIL flush_regwrite got %0d want 0", ex_reg_write); else passCount++;
    flush = 1'b0;
    tick();
    checkCount++; if (ex_a !== 32'h70) $display("FAIL flush_next_a got %h want 70", ex_a); else passCount++;
    setInstr(1, 5'd5, 5'd6, 5'd15, 32'h99, 32'h98, 32'h0, FN_SLT, ALU_LT, 0, 1, 0, 0, 0);
    flush = 1'b1; ex_hold = 1'b1;
    #1;
    checkCount++; if (stall_out !== 1'b1) $display("FAIL hold_stall got %0d want 1", stall_out); else passCount++;
    tick();
    checkCount++; if (ex_valid !== 1'b1) $display("FAIL hold_valid got %0d want 1", ex_valid); else passCount++;
    checkCount++; if (ex_rd !== 5'd14) $display("FAIL hold_rd got %0d want 14", ex_rd); else passCount++;
    checkCount++; if (ex_a !== 32'h70) $display("FAIL hold_a got %h want 70", ex_a); else passCount++;
    flush = 1'b0; ex_hold = 1'b0;
  endtask

  task automatic test_raw_stall();
    setInstr(1, 5'd14, 5'd0, 5'd16, 32'h123, 32'h0, 32'h0, FN_ADD, ALU_ARITH, 0, 1, 0, 0, 0);
    #1;
`ifdef FWD_EN
    checkCount++; if (stall_out !== 1'b0) $display("FAIL raw_fwd_stall got %0d want 0", stall_out); else passCount++;
`else
    checkCount++; if (stall_out !== 1'b1) $display("FAIL raw_ex_stall got %0d want 1", stall_out); else passCount++;
    tick();
    checkCount++; if (ex_valid !== 1'b0) $display("FAIL raw_bubble got %0d want 0", ex_valid); else passCount++;
    exmem_reg_write = 1; exmem_rd = 5'd14; exmem_result = 32'h5;
    #1;
    checkCount++; if (stall_out !== 1'b1) $display("FAIL raw_exmem_stall got %0d want 1", stall_out); else passCount++;
    tick();
    idleProducers();
    memwb_reg_write = 1; memwb_rd = 5'd14; memwb_data = 32'h5;
    #1;
    checkCount++; if (stall_out !== 1'b1) $display("FAIL raw_memwb_stall got %0d want 1", stall_out); else passCount++;
    tick();
    idleProducers();
    #1;
    checkCount++; if (stall_out !== 1'b0) $display("FAIL raw_clear_stall got %0d want 0", stall_out); else passCount++;
`endif
    tick();
    checkCount++; if (ex_rd !== 5'd16) $display("FAIL raw_enter_rd got %0d want 16", ex_rd); else passCount++;
    checkCount++; if (ex_valid !== 1'b1) $display("FAIL raw_enter_valid got %0d want 1", ex_valid); else passCount++;
  endtask

  task automatic test_reset_mid_stall();
    setInstr(1, 5'd1, 5'd0, 5'd8, 32'h40, 32'h0, 32'h4, FN_ADD, ALU_ADDI, 1, 1, 1, 0, 1);
    tick();
    setInstr(1, 5'd8, 5'd0, 5'd9, 32'h50, 32'h0, 32'h0, FN_ADD, ALU_ARITH, 0, 1, 0, 0, 0);
    #1;
    checkCount++; if (stall_out !== 1'b1) $display("FAIL rms_stall got %0d want 1", stall_out); else passCount++;
    reset = 1'b1;
    tick();
    checkCount++; if (stall_out !== 1'b0) $display("FAIL rms_stall_drop got %0d want 0", stall_out); else passCount++;
    checkCount++; if (ex_valid !== 1'b0) $display("FAIL rms_valid got %0d want 0", ex_valid); else passCount++;
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_operands();
    test_forward();
    test_load_use();
    test_flush_hold();
    test_raw_stall();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
